// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle for branch_resolve_queue.
//   master : fetch/execute side (drives predictions and resolutions)
//   slave  : the queue itself
// Signals: pred_* (enqueue handshake), res_* (resolution of the oldest
// branch), upd_* / mispredict / redirect_pc (registered strobes),
// count, res_err, stat_resolved, stat_mispred (status).
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pred_valid;
  logic            pred_ready;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   count;
  logic            res_err;
  logic [15:0]     stat_resolved;
  logic [15:0]     stat_mispred;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
           res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_pc, upd_taken, mispredict,
           redirect_pc, count, res_err, stat_resolved, stat_mispred
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
           res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_pc, upd_taken, mispredict,
           redirect_pc, count, res_err, stat_resolved, stat_mispred
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds in-flight predicted branches in order, checks
// each against its resolution from execute, emits a predictor-update strobe
// and, on a wrong prediction, a flush/redirect strobe.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous reset, active HIGH (legacy name)
//   bus      : branch_resolve_queue_if.slave (see interface file)
// Optional feature macro: BRQ_STATS_EN enables the 16-bit saturating
// resolve/mispredict counters; without it both counters read 0.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  branch_resolve_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            upd_valid_q, upd_taken_q, mispredict_q, res_err_q;
  logic [XLEN-1:0] upd_pc_q, redirect_pc_q;

  entry_t head;
  logic   full, enq, res, mis;

  assign head = mem_q[rd_q];
  assign full = (count_q == CW'(DEPTH));
  assign bus.pred_ready = !full && !reset_n;
  assign enq  = bus.pred_valid && bus.pred_ready;
  assign res  = bus.res_valid && (count_q != '0);
  // Target only matters when both sides agree the branch was taken.
  assign mis  = res && ((bus.res_taken != head.taken) ||
                        (bus.res_taken && (bus.res_target != head.target)));

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (mis) begin
      // Flush everything younger; a same-cycle enqueue is on the wrong path.
      rd_d    = wr_q;
      count_d = '0;
    end else begin
      wr_d    = wr_q + PW'(enq);
      rd_d    = rd_q + PW'(res);
      count_d = count_q + CW'(enq) - CW'(res);
    end
  end

  // Entry storage needs no reset: only slots between rd and wr are ever read.
  always_ff @(posedge clk) begin
    if (enq && !mis) mem_q[wr_q] <= '{pc: bus.pred_pc, taken: bus.pred_taken,
                                     target: bus.pred_target};
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_q          <= '0;
      rd_q          <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      res_err_q     <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      upd_valid_q  <= res;
      mispredict_q <= mis;
      if (res) begin
        upd_pc_q      <= head.pc;
        upd_taken_q   <= bus.res_taken;
        redirect_pc_q <= bus.res_taken ? bus.res_target : head.pc + XLEN'(4);
      end
      if (bus.res_valid && (count_q == '0)) res_err_q <= 1'b1;
    end
  end

  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.count       = count_q;
  assign bus.res_err     = res_err_q;

`ifdef BRQ_STATS_EN
  logic [15:0] stat_res_q, stat_mis_q;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (res && (stat_res_q != 16'hFFFF)) stat_res_q <= stat_res_q + 16'd1;
      if (mis && (stat_mis_q != 16'hFFFF)) stat_mis_q <= stat_mis_q + 16'd1;
    end
  end

  assign bus.stat_resolved = stat_res_q;
  assign bus.stat_mispred  = stat_mis_q;
`else
  assign bus.stat_resolved = '0;
  assign bus.stat_mispred  = '0;
`endif
endmodule
